// File: rtl/pu_or1k_apb4_result_checker_if.sv
// APB4 slave-side bus bundle for the OR1K result checker.
// Signals: psel/penable/pwrite/paddr/pwdata/pstrb from the master,
//          pready/prdata/pslverr back from the slave.
interface pu_or1k_apb4_result_checker_if #(
  parameter int unsigned PADDR_SIZE = 8,
  parameter int unsigned PDATA_SIZE = 32
) ();
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [PADDR_SIZE-1:0]     paddr;
  logic [PDATA_SIZE-1:0]     pwdata;
  logic [PDATA_SIZE/8-1:0]   pstrb;
  logic                      pready;
  logic [PDATA_SIZE-1:0]     prdata;
  logic                      pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/pu_or1k_apb4_result_checker.sv
// Testcase result checker: software writes RESULT/EXIT registers over APB4,
// each RESULT becomes an event {ok, id, code} queued in a FIFO and streamed
// out on tc_valid/tc_ready; pass/fail totals produce a final done/done_pass.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   apb (slave)       - APB4 register port (RESULT 0x0, EXIT 0x4, COUNT 0x8)
//   tc_valid/tc_ready - downstream event handshake
//   tc_ok/tc_id/tc_code - head event payload
//   done/done_pass    - exit latched and FIFO drained / overall verdict
// Optional: define PU_OR1K_RESULT_CHECKER_WATCHDOG_EN to add an idle watchdog
// that injects a failing event (code 0xDEAD) and forces exit.
module pu_or1k_apb4_result_checker #(
  parameter int unsigned PADDR_SIZE     = 8,
  parameter int unsigned PDATA_SIZE     = 32,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned NUM_TESTS      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                                 clk,
  input  logic                                 rst,
  pu_or1k_apb4_result_checker_if.slave         apb,
  output logic                                 tc_valid,
  input  logic                                 tc_ready,
  output logic                                 tc_ok,
  output logic [15:0]                          tc_id,
  output logic [15:0]                          tc_code,
  output logic                                 done,
  output logic                                 done_pass
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [1:0]  A_RESULT = 2'd0;
  localparam logic [1:0]  A_EXIT   = 2'd1;
  localparam logic [1:0]  A_COUNT  = 2'd2;

  typedef struct packed {
    logic        ok;
    logic [15:0] id;
    logic [15:0] code;
  } tc_evt_t;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_DONE = 2'd2} state_t;

  state_t         state;
  tc_evt_t        mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr;
  logic [15:0]    issued, fail_cnt;
  logic           exit_seen, exit_ok;

  logic        access, err, limit_hit;
  logic [1:0]  addr;
  logic        result_wr, exit_wr, stall, apb_push, wd_push, push, pop;
  logic        empty, full, drain_hold, fail_inc;
  tc_evt_t     head, push_evt;

  // FIFO status; the extra pointer MSB separates full from empty
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = !empty && tc_ready;

  // APB decode
  assign access    = apb.psel && apb.penable;
  assign addr      = apb.paddr[3:2];
  assign limit_hit = (NUM_TESTS != 0) && (issued == 16'(NUM_TESTS));

  always_comb begin
    err = 1'b1;
    case (addr)
      A_RESULT: err = !apb.pwrite || limit_hit || exit_seen;
      A_EXIT:   err = !apb.pwrite || exit_seen;
      A_COUNT:  err = apb.pwrite;
      default:  err = 1'b1;
    endcase
  end

  assign result_wr = access && apb.pwrite && (addr == A_RESULT) && !err;
  assign exit_wr   = access && apb.pwrite && (addr == A_EXIT) && !err;
  // A same-cycle pop frees the slot, so a push at full need not wait
  assign stall     = result_wr && full && !pop;
  assign apb_push  = result_wr && !stall;
  assign push      = apb_push || wd_push;
  assign fail_inc  = (apb_push && !apb.pwdata[0]) || wd_push;

  assign apb.pready  = !stall;
  assign apb.pslverr = access && err;
  assign apb.prdata  = (access && !apb.pwrite && (addr == A_COUNT)) ?
                       PDATA_SIZE'({fail_cnt, issued}) : '0;

  always_comb begin
    push_evt.ok   = 1'b0;
    push_evt.id   = 16'(issued + 16'd1);
    push_evt.code = 16'hDEAD;
    if (apb_push) begin
      push_evt.ok   = apb.pwdata[0];
      push_evt.code = apb.pwdata[31:16];
    end
  end

  // Head entry drives the event outputs; zeroed while the FIFO is empty
  assign head     = mem[rd_ptr[PTR_W-1:0]];
  assign tc_valid = !empty;
  assign tc_ok    = !empty && head.ok;
  assign tc_id    = empty ? 16'd0 : head.id;
  assign tc_code  = empty ? 16'd0 : head.code;

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= push_evt;
  end

  // Pointers, counters, exit latch and output state machine
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      issued    <= '0;
      fail_cnt  <= '0;
      exit_seen <= 1'b0;
      exit_ok   <= 1'b0;
      done      <= 1'b0;
      done_pass <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (apb_push && issued != 16'hFFFF)   issued   <= issued + 16'd1;
      if (fail_inc && fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
      if (exit_wr || wd_push) begin
        exit_seen <= 1'b1;
        exit_ok   <= wd_push ? 1'b0 : apb.pwdata[0];
      end
      case (state)
        S_IDLE:  if (exit_wr || wd_push) state <= S_DRAIN;
        S_DRAIN: if (empty && !drain_hold) begin
          state     <= S_DONE;
          done      <= 1'b1;
          done_pass <= exit_ok && (fail_cnt == 16'd0) &&
                       ((NUM_TESTS == 0) || (issued == 16'(NUM_TESTS)));
        end
        default: state <= S_DONE;
      endcase
    end
  end

`ifdef PU_OR1K_RESULT_CHECKER_WATCHDOG_EN
  // Idle watchdog: counts cycles without a completed APB access while IDLE
  logic [31:0] wd_cnt;
  logic        wd_pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      wd_pend <= 1'b0;
    end else begin
      if (wd_push) wd_pend <= 1'b0;
      if (access && !stall) begin
        wd_cnt <= '0;
      end else if (state == S_IDLE && !wd_pend) begin
        if (wd_cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
          wd_pend <= 1'b1;
          wd_cnt  <= '0;
        end else begin
          wd_cnt <= wd_cnt + 32'd1;
        end
      end
    end
  end

  // Synthetic event yields to an APB push and waits for FIFO space
  assign wd_push    = wd_pend && !apb_push && (!full || pop);
  assign drain_hold = wd_pend;
`else
  assign wd_push    = 1'b0;
  assign drain_hold = 1'b0;
`endif

  // Bits and parameters intentionally not decoded
  logic unused_bits;
  assign unused_bits = ^{apb.pstrb, apb.paddr, apb.pwdata[15:1],
                         32'(PADDR_SIZE), 32'(TIMEOUT_CYCLES)};

endmodule

// File: tb/tb_pu_or1k_apb4_result_checker.sv
// Self-checking bench: two checker instances (NUM_TESTS=2 and NUM_TESTS=0)
// share the APB stimulus, selected by 'sel'; a scoreboard queue holds the
// expected events and the monitor compares them at each handshake.
module tb_pu_or1k_apb4_result_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic        tc_ready = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] sb [$];
  logic [32:0] sb_exp;

  always #5 clk = ~clk;

  pu_or1k_apb4_result_checker_if #(.PADDR_SIZE(8), .PDATA_SIZE(32)) apb_a ();
  pu_or1k_apb4_result_checker_if #(.PADDR_SIZE(8), .PDATA_SIZE(32)) apb_b ();

  assign apb_a.psel = psel & ~sel;   assign apb_b.psel = psel & sel;
  assign apb_a.penable = penable;    assign apb_b.penable = penable;
  assign apb_a.pwrite = pwrite;      assign apb_b.pwrite = pwrite;
  assign apb_a.paddr = paddr;        assign apb_b.paddr = paddr;
  assign apb_a.pwdata = pwdata;      assign apb_b.pwdata = pwdata;
  assign apb_a.pstrb = 4'hF;         assign apb_b.pstrb = 4'hF;

  logic        tc_valid_a, tc_ok_a, done_a, done_pass_a;
  logic [15:0] tc_id_a, tc_code_a;
  logic        tc_valid_b, tc_ok_b, done_b, done_pass_b;
  logic [15:0] tc_id_b, tc_code_b;

  // Unlimited testcase count
  pu_or1k_apb4_result_checker #(
    .PADDR_SIZE(8), .PDATA_SIZE(32), .FIFO_DEPTH(4), .NUM_TESTS(0), .TIMEOUT_CYCLES(50)
  ) u_dut_unl (
    .clk(clk), .rst(rst), .apb(apb_a.slave),
    .tc_valid(tc_valid_a), .tc_ready(tc_ready), .tc_ok(tc_ok_a),
    .tc_id(tc_id_a), .tc_code(tc_code_a), .done(done_a), .done_pass(done_pass_a)
  );

  // Exactly two testcases expected
  pu_or1k_apb4_result_checker #(
    .PADDR_SIZE(8), .PDATA_SIZE(32), .FIFO_DEPTH(4), .NUM_TESTS(2), .TIMEOUT_CYCLES(50)
  ) u_dut_n2 (
    .clk(clk), .rst(rst), .apb(apb_b.slave),
    .tc_valid(tc_valid_b), .tc_ready(tc_ready), .tc_ok(tc_ok_b),
    .tc_id(tc_id_b), .tc_code(tc_code_b), .done(done_b), .done_pass(done_pass_b)
  );

  logic        pready_m, pslverr_m, tc_valid_m, tc_ok_m, done_m, done_pass_m;
  logic [31:0] prdata_m;
  logic [15:0] tc_id_m, tc_code_m;

  assign pready_m    = sel ? apb_b.pready  : apb_a.pready;
  assign pslverr_m   = sel ? apb_b.pslverr : apb_a.pslverr;
  assign prdata_m    = sel ? apb_b.prdata  : apb_a.prdata;
  assign tc_valid_m  = sel ? tc_valid_b    : tc_valid_a;
  assign tc_ok_m     = sel ? tc_ok_b       : tc_ok_a;
  assign tc_id_m     = sel ? tc_id_b       : tc_id_a;
  assign tc_code_m   = sel ? tc_code_b     : tc_code_a;
  assign done_m      = sel ? done_b        : done_a;
  assign done_pass_m = sel ? done_pass_b   : done_pass_a;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard monitor: every handshake pops one expected event
  always @(negedge clk) begin
    if (!rst && tc_valid_m && tc_ready) begin
      if (sb.size() == 0) begin
        check("sb_extra", 64'({tc_ok_m, tc_id_m, tc_code_m}), 64'd0);
      end else begin
        sb_exp = sb.pop_front();
        check("tc_evt", 64'({tc_ok_m, tc_id_m, tc_code_m}), 64'(sb_exp));
      end
    end
  end

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data,
                          output logic [31:0] rdata, output logic err, output int waits);
    waits = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    while (!pready_m && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!pready_m) check("apb_timeout", 64'(pready_m), 64'd1);
    rdata = prdata_m;
    err   = pslverr_m;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr_reg(input string tag, input logic [7:0] addr, input logic [31:0] data,
                        input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b1, addr, data, rd, e, w);
    check(tag, 64'(e), 64'(exp_err));
  endtask

  task automatic rd_reg(input string tag, input logic [7:0] addr, input logic [31:0] exp_data,
                        input logic exp_err);
    logic [31:0] rd;
    logic        e;
    int          w;
    apb_xfer(1'b0, addr, 32'd0, rd, e, w);
    check(tag, 64'({e, rd}), 64'({exp_err, exp_data}));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done_m) break;
    end
    check(tag, 64'(done_m), 64'd1);
  endtask

  task automatic drain_check(input string tag);
    repeat (10) @(negedge clk);
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          w;

    // Reset values (NUM_TESTS=2 instance)
    sel = 1'b1;
    do_reset();
    @(negedge clk);
    check("rst_pready",  64'(pready_m),    64'd1);
    check("rst_pslverr", 64'(pslverr_m),   64'd0);
    check("rst_prdata",  64'(prdata_m),    64'd0);
    check("rst_tc",      64'({tc_valid_m, tc_ok_m, tc_id_m, tc_code_m}), 64'd0);
    check("rst_done",    64'({done_m, done_pass_m}), 64'd0);

    // Pass sequence
    tc_ready = 1'b1;
    sb.push_back({1'b1, 16'd1, 16'd1});
    wr_reg("pass_res1", 8'h0, 32'h0001_0001, 1'b0);
    sb.push_back({1'b1, 16'd2, 16'd2});
    wr_reg("pass_res2", 8'h0, 32'h0002_0001, 1'b0);
    rd_reg("pass_count", 8'h8, 32'h0000_0002, 1'b0);
    wr_reg("pass_exit", 8'h4, 32'h1, 1'b0);
    @(negedge clk);
    check("done_early", 64'(done_m), 64'd0);
    @(negedge clk);
    check("done_lat",   64'(done_m), 64'd1);
    check("pass_verdict", 64'(done_pass_m), 64'd1);
    check("pass_sb_empty", 64'(sb.size()), 64'd0);

    // Error responses with NUM_TESTS=2
    do_reset();
    rd_reg("err_rd_result", 8'h0, 32'd0, 1'b1);
    rd_reg("err_rd_exit",   8'h4, 32'd0, 1'b1);
    wr_reg("err_wr_unmap",  8'hC, 32'h1, 1'b1);
    wr_reg("err_wr_count",  8'h8, 32'h1, 1'b1);
    rd_reg("err_count0",    8'h8, 32'd0, 1'b0);
    sb.push_back({1'b1, 16'd1, 16'h0010});
    wr_reg("err_res1", 8'h0, 32'h0010_0001, 1'b0);
    sb.push_back({1'b0, 16'd2, 16'h0020});
    wr_reg("err_res2", 8'h0, 32'h0020_0000, 1'b0);
    wr_reg("err_res3_limit", 8'h0, 32'h0030_0001, 1'b1);
    rd_reg("err_count2", 8'h8, 32'h0001_0002, 1'b0);
    wr_reg("err_exit", 8'h4, 32'h1, 1'b0);
    wr_reg("err_res_after_exit",  8'h0, 32'h0040_0001, 1'b1);
    wr_reg("err_exit_after_exit", 8'h4, 32'h1, 1'b1);
    rd_reg("err_count_final", 8'h8, 32'h0001_0002, 1'b0);
    wait_done("err_done");
    check("err_verdict", 64'(done_pass_m), 64'd0);
    drain_check("err_sb_empty");

    // Failure (unlimited instance), also checks event latency
    sel = 1'b0;
    do_reset();
    tc_ready = 1'b0;
    sb.push_back({1'b0, 16'd1, 16'd7});
    wr_reg("fail_res", 8'h0, 32'h0007_0000, 1'b0);
    @(negedge clk);
    check("evt_lat", 64'({tc_valid_m, tc_ok_m, tc_id_m, tc_code_m}), 64'({1'b1, 1'b0, 16'd1, 16'd7}));
    tc_ready = 1'b1;
    rd_reg("fail_count", 8'h8, 32'h0001_0001, 1'b0);
    wr_reg("fail_exit", 8'h4, 32'h1, 1'b0);
    wait_done("fail_done");
    check("fail_verdict", 64'(done_pass_m), 64'd0);
    check("fail_sb_empty", 64'(sb.size()), 64'd0);

    // Backpressure: 5th RESULT stalls until tc_ready pulses
    do_reset();
    tc_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sb.push_back({1'b1, 16'(i), 16'(i)});
      wr_reg("bp_res", 8'h0, {16'(i), 16'h0001}, 1'b0);
    end
    sb.push_back({1'b1, 16'd5, 16'd5});
    fork
      apb_xfer(1'b1, 8'h0, 32'h0005_0001, rd, e, w);
      begin
        repeat (5) @(posedge clk);
        #1 tc_ready = 1'b1;
        @(posedge clk);
        #1 tc_ready = 1'b0;
      end
    join
    check("bp_stall", 64'(w != 0), 64'd1);
    check("bp_err",   64'(e), 64'd0);
    check("bp_head",  64'({tc_valid_m, tc_id_m}), 64'({1'b1, 16'd2}));
    tc_ready = 1'b1;
    drain_check("bp_sb_empty");
    check("bp_valid_low", 64'(tc_valid_m), 64'd0);

    // Reset mid-operation
    do_reset();
    tc_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      wr_reg("mid_res", 8'h0, {16'(i + 8), 16'h0001}, 1'b0);
    end
    check("mid_valid_pre", 64'(tc_valid_m), 64'd1);
    do_reset();
    @(negedge clk);
    check("mid_valid", 64'(tc_valid_m), 64'd0);
    check("mid_done",  64'(done_m), 64'd0);
    rd_reg("mid_count", 8'h8, 32'd0, 1'b0);
    sb.push_back({1'b1, 16'd1, 16'd5});
    wr_reg("mid_res_new", 8'h0, 32'h0005_0001, 1'b0);
    tc_ready = 1'b1;
    drain_check("mid_sb_empty");

`ifdef PU_OR1K_RESULT_CHECKER_WATCHDOG_EN
    // Watchdog fires after 50 idle cycles
    do_reset();
    tc_ready = 1'b1;
    sb.push_back({1'b0, 16'd1, 16'hDEAD});
    wait_done("wd_done");
    check("wd_verdict", 64'(done_pass_m), 64'd0);
    check("wd_sb_empty", 64'(sb.size()), 64'd0);
`else
    // Without the watchdog the block waits indefinitely for EXIT
    do_reset();
    tc_ready = 1'b1;
    repeat (120) @(negedge clk);
    check("nowd_done",  64'(done_m), 64'd0);
    check("nowd_valid", 64'(tc_valid_m), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
